// File: rtl/spi_adc_scan.sv
// spi_adc_scan: SPI A/D scan controller for up to 8 ADC128S-style devices.
// Runs single conversions or hardware scans (optionally continuous) into an
// on-chip result buffer that the CPU reads over the 8-bit I/O bus.
`timescale 1ns/1ps
module spi_adc_scan #(
  parameter int N_DEV   = 4,
  parameter int N_IN    = 8,
  parameter int RES     = 12,
  parameter int DIV_RST = 5
) (
  input  logic             Xin,
  input  logic             nRESET,
  input  logic             cs,
  input  logic             wr,
  input  logic             rd,
  input  logic [2:0]       addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  output logic             SCLK,
  output logic             MOSI,
  input  logic             MISO,
  output logic [N_DEV-1:0] nCS,
  output logic             busy,
  output logic             irq
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam logic [3:0] NDEV_W   = 4'(N_DEV);
  localparam logic [3:0] NIN_W    = 4'(N_IN);
  localparam logic [2:0] LAST_DEV = 3'(N_DEV - 1);
  localparam logic [2:0] LAST_IN  = 3'(N_IN - 1);
  localparam logic [5:0] LAST_IDX = 6'(N_DEV * N_IN - 1);
  localparam logic [5:0] NIN6     = 6'(N_IN);

  // FSM / frame datapath state
  logic [2:0]     state_q, state_d;
  logic [8:0]     cnt_q, cnt_d;     // Xin cycles left in current phase/half-period
  logic [7:0]     dl_q, dl_d;       // DIV latched at frame start
  logic [4:0]     hp_q, hp_d;       // SCLK half-period index within SHIFT
  logic [RES-1:0] sh_q, sh_d;       // MISO shift register, keeps the last RES bits
  logic [2:0]     dev_q, dev_d;
  logic [2:0]     in_q, in_d;
  logic           scan_q, scan_d;
  logic           cont_q, cont_d;

  // CPU-visible registers
  logic [7:0]     div_q, div_d;
  logic [5:0]     ridx_q, ridx_d;
  logic           done_q, done_d;
  logic           ovr_q, ovr_d;
  logic [3:0]     hi_q, hi_d;
  logic [7:0]     rdata_q, rdata_d;

  // Result buffer sized to the full 6-bit index space; unused entries stay 0.
  logic [11:0]    buf_q [64];

  logic [7:0]  div_eff;
  logic [8:0]  div_m1, half_m1, gap_m1;
  logic        cmd_wr, cmd_ok, start;
  logic        store, last_ch, more, pass_end, frame_act;
  logic [5:0]  chan_idx;
  logic [11:0] res12, rd_word;

  assign div_eff  = (div_q == 8'd0) ? 8'd1 : div_q;
  assign div_m1   = {1'b0, div_eff} - 9'd1;
  assign half_m1  = {1'b0, dl_q} - 9'd1;
  assign gap_m1   = {dl_q, 1'b0} - 9'd1;

  assign cmd_wr   = cs && wr && (addr == 3'd0);
  assign cmd_ok   = ({1'b0, wdata[5:3]} < NDEV_W) && ({1'b0, wdata[2:0]} < NIN_W);
  assign start    = cmd_wr && (state_q == S_IDLE) && cmd_ok;

  assign store    = (state_q == S_STORE);
  assign last_ch  = (dev_q == LAST_DEV) && (in_q == LAST_IN);
  // A CMD write landing on the final STORE already counts as the stop request.
  assign more     = scan_q && (!last_ch || (cont_q && !cmd_wr));
  assign pass_end = store && (!scan_q || last_ch);
  assign chan_idx = 6'(dev_q) * NIN6 + 6'(in_q);
  assign res12    = 12'(sh_q);

  assign frame_act = (state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD);

  // Next-state logic for the frame sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dl_d    = dl_q;
    hp_d    = hp_q;
    sh_d    = sh_q;
    dev_d   = dev_q;
    in_d    = in_q;
    scan_d  = scan_q;
    cont_d  = cont_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          dl_d    = div_eff;
          cnt_d   = div_m1;
          scan_d  = wdata[6];
          cont_d  = wdata[6] & wdata[7];
          dev_d   = wdata[6] ? 3'd0 : wdata[5:3];
          in_d    = wdata[6] ? 3'd0 : wdata[2:0];
        end
      end
      S_SETUP: begin
        if (cnt_q == 9'd0) begin
          state_d = S_SHIFT;
          hp_d    = 5'd0;
          cnt_d   = half_m1;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == 9'd0) begin
          cnt_d = half_m1;
          // Leaving an even (low) half-period is an SCLK rising edge.
          if (!hp_q[0]) sh_d = {sh_q[RES-2:0], MISO};
          if (hp_q == 5'd31) state_d = S_HOLD;
          else               hp_d    = hp_q + 5'd1;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 9'd0) state_d = S_STORE;
        else               cnt_d   = cnt_q - 9'd1;
      end
      S_STORE: begin
        if (more) begin
          state_d = S_GAP;
          cnt_d   = gap_m1;
          if (in_q == LAST_IN) begin
            in_d  = 3'd0;
            dev_d = (dev_q == LAST_DEV) ? 3'd0 : dev_q + 3'd1;
          end else begin
            in_d  = in_q + 3'd1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (cnt_q == 9'd0) begin
          state_d = S_SETUP;
          dl_d    = div_eff;
          cnt_d   = div_m1;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (cmd_wr && (state_q != S_IDLE) && cont_q) cont_d = 1'b0;
  end

  // Frame sequencer registers
  always_ff @(posedge Xin or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dl_q    <= 8'd1;
      hp_q    <= '0;
      sh_q    <= '0;
      dev_q   <= '0;
      in_q    <= '0;
      scan_q  <= 1'b0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dl_q    <= dl_d;
      hp_q    <= hp_d;
      sh_q    <= sh_d;
      dev_q   <= dev_d;
      in_q    <= in_d;
      scan_q  <= scan_d;
      cont_q  <= cont_d;
    end
  end

  // Buffer read port; a STORE to the index being read is forwarded.
  always_comb begin
    rd_word = '0;
    if (store && (chan_idx == ridx_q)) rd_word = res12;
    else if (ridx_q <= LAST_IDX)       rd_word = buf_q[ridx_q];
  end

  // CPU register file: writes, reads, flag set/clear priority
  always_comb begin
    div_d   = div_q;
    ridx_d  = ridx_q;
    done_d  = done_q;
    ovr_d   = ovr_q;
    hi_d    = hi_q;
    rdata_d = rdata_q;
    if (cs && wr) begin
      case (addr)
        3'd1:    div_d  = wdata;
        3'd5:    ridx_d = wdata[5:0];
        default: ;
      endcase
    end
    if (cs && rd) begin
      case (addr)
        3'd1: rdata_d = div_q;
        3'd2: begin
          rdata_d = {2'b00, ovr_q, done_q, dev_q, busy};
          done_d  = 1'b0;
          ovr_d   = 1'b0;
        end
        3'd3: begin
          rdata_d = rd_word[7:0];
          hi_d    = rd_word[11:8];
        end
        3'd4: begin
          rdata_d = {4'h0, hi_q};
          ridx_d  = (ridx_q >= LAST_IDX) ? 6'd0 : ridx_q + 6'd1;
        end
        3'd5:    rdata_d = {2'b00, ridx_q};
        default: rdata_d = 8'h00;
      endcase
    end
    // Set events override a coincident STATUS-read clear.
    if (cmd_wr && ((state_q == S_IDLE) ? !cmd_ok : !cont_q)) ovr_d = 1'b1;
    if (pass_end) done_d = 1'b1;
    // A completing single conversion points RIDX at its own result.
    if (store && !scan_q) ridx_d = chan_idx;
  end

  // CPU register file registers
  always_ff @(posedge Xin or negedge nRESET) begin
    if (!nRESET) begin
      div_q   <= 8'(DIV_RST);
      ridx_q  <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      hi_q    <= '0;
      rdata_q <= '0;
    end else begin
      div_q   <= div_d;
      ridx_q  <= ridx_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      hi_q    <= hi_d;
      rdata_q <= rdata_d;
    end
  end

  // Result buffer write on STORE
  always_ff @(posedge Xin or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < 64; i++) buf_q[i] <= '0;
    end else if (store) begin
      buf_q[chan_idx] <= res12;
    end
  end

  // Device select: exactly one line low while a frame is on the wire
  always_comb begin
    nCS = '1;
    for (int d = 0; d < N_DEV; d++)
      if (frame_act && (dev_q == 3'(d))) nCS[d] = 1'b0;
  end

  // SCLK low on even half-periods; MOSI carries A2..A0 on falls 3..5
  always_comb begin
    SCLK = (state_q == S_SHIFT) ? hp_q[0] : 1'b1;
    MOSI = 1'b0;
    if (state_q == S_SHIFT) begin
      case (hp_q[4:1])
        4'd2:    MOSI = in_q[2];
        4'd3:    MOSI = in_q[1];
        4'd4:    MOSI = in_q[0];
        default: MOSI = 1'b0;
      endcase
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign irq   = done_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_spi_adc_scan.sv
// Bench for spi_adc_scan: behavioural ADC model with random conversion
// values, a result-buffer scoreboard, a register vector table and
// directed sequences for single/scan/continuous/overrun/reset cases.
`timescale 1ns/1ps
module tb_spi_adc_scan;
  localparam int N_DEV = 4, N_IN = 8, RES = 12, DIV_RST = 5, NCH = N_DEV * N_IN;

  logic Xin = 0, nRESET = 0, cs = 0, wr = 0, rd = 0, MISO = 0;
  logic [2:0] addr = 0;
  logic [7:0] wdata = 0;
  logic [7:0] rdata;
  logic SCLK, MOSI, busy, irq;
  logic [N_DEV-1:0] nCS;
  int checks = 0, errors = 0;

  spi_adc_scan #(.N_DEV(N_DEV), .N_IN(N_IN), .RES(RES), .DIV_RST(DIV_RST)) dut (
    .Xin(Xin), .nRESET(nRESET), .cs(cs), .wr(wr), .rd(rd), .addr(addr),
    .wdata(wdata), .rdata(rdata), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .nCS(nCS), .busy(busy), .irq(irq));

  always #5 Xin = ~Xin;

  // ---------------- ADC model + scoreboard ----------------
  typedef struct {int dev; int ch; int val;} frame_t;
  frame_t fq[$];
  int exp_buf [NCH];
  logic act = 0, prev_sclk = 1, ncs_bad = 0, mosi_bad = 0;
  int falls = 0, rises = 0, cur_dev = 0, cur_val = 0, cur_ch = 0, zeros = 0;

  always @(negedge Xin) begin
    if (!nRESET) begin
      act = 0; falls = 0; rises = 0; MISO = 0;
      for (int i = 0; i < NCH; i++) exp_buf[i] = 0;
    end else begin
      zeros = 0;
      for (int d = 0; d < N_DEV; d++) if (!nCS[d]) zeros++;
      if (zeros > 1) ncs_bad = 1;
      if (!act && zeros == 1) begin
        act = 1; falls = 0; rises = 0; cur_ch = 0;
        cur_val = int'($urandom_range(0, 4095));
        for (int d = 0; d < N_DEV; d++) if (!nCS[d]) cur_dev = d;
      end
      if (act) begin
        if (prev_sclk && !SCLK) begin
          falls++;
          if (falls >= 17 - RES && falls <= 16) MISO = cur_val[16 - falls];
          else MISO = 1'($urandom);
        end
        if (!prev_sclk && SCLK) begin
          rises++;
          if (rises >= 3 && rises <= 5) cur_ch = cur_ch * 2 + int'(MOSI);
          else if (MOSI) mosi_bad = 1;
        end
        if (zeros == 0) begin
          act = 0;
          if (rises == 16) begin
            fq.push_back('{cur_dev, cur_ch, cur_val});
            exp_buf[cur_dev * N_IN + cur_ch] = cur_val;
          end
        end
      end
    end
    prev_sclk = SCLK;
  end

  // ---------------- helpers ----------------
  int fidx = 0;

  task automatic chk(input string nm, input int act_v, input int exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act_v, act_v, exp_v, exp_v);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge Xin); cs = 1; wr = 1; addr = a; wdata = d;
    @(negedge Xin); cs = 0; wr = 0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge Xin); cs = 1; rd = 1; addr = a;
    @(negedge Xin); cs = 0; rd = 0; d = rdata;
  endtask

  task automatic read_pair(output int v);
    logic [7:0] lo, hi;
    bus_rd(3'd3, lo);
    bus_rd(3'd4, hi);
    v = int'(hi) * 256 + int'(lo);
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (busy && n < limit) begin n++; @(negedge Xin); end
    if (busy) begin
      checks++; errors++;
      $display("FAIL busy_timeout: busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic chk_frame(input string nm, input int d, input int c);
    checks++;
    if (fidx >= fq.size()) begin
      errors++;
      $display("FAIL %s: no frame captured, required dev %0d in %0d", nm, d, c);
    end else begin
      if (fq[fidx].dev != d || fq[fidx].ch != c) begin
        errors++;
        $display("FAIL %s: got dev %0d in %0d, required dev %0d in %0d",
                 nm, fq[fidx].dev, fq[fidx].ch, d, c);
      end
      fidx++;
    end
  endtask

  // ---------------- register vector table ----------------
  typedef struct {logic is_wr; logic [2:0] a; logic [7:0] d; logic [7:0] exp;} vec_t;
  vec_t vt[19];

  initial begin
    logic [7:0] st, r8;
    int n, v, dv, deff, dev, ch, busy_seen;

    vt[0]  = '{1'b0, 3'd2, 8'h00, 8'h00};  // STATUS after reset
    vt[1]  = '{1'b0, 3'd1, 8'h00, 8'h05};  // DIV reset value
    vt[2]  = '{1'b0, 3'd5, 8'h00, 8'h00};  // RIDX reset
    vt[3]  = '{1'b1, 3'd5, 8'h07, 8'h00};
    vt[4]  = '{1'b0, 3'd5, 8'h00, 8'h07};
    vt[5]  = '{1'b0, 3'd3, 8'h00, 8'h00};  // buffer is zero after reset
    vt[6]  = '{1'b0, 3'd4, 8'h00, 8'h00};
    vt[7]  = '{1'b0, 3'd5, 8'h00, 8'h08};  // DATA_HI post-incremented
    vt[8]  = '{1'b1, 3'd5, 8'h1F, 8'h00};
    vt[9]  = '{1'b0, 3'd4, 8'h00, 8'h00};
    vt[10] = '{1'b0, 3'd5, 8'h00, 8'h00};  // wrap 31 -> 0
    vt[11] = '{1'b1, 3'd6, 8'hFF, 8'h00};
    vt[12] = '{1'b0, 3'd6, 8'h00, 8'h00};
    vt[13] = '{1'b0, 3'd7, 8'h00, 8'h00};
    vt[14] = '{1'b0, 3'd0, 8'h00, 8'h00};
    vt[15] = '{1'b1, 3'd1, 8'h03, 8'h00};
    vt[16] = '{1'b0, 3'd1, 8'h00, 8'h03};
    vt[17] = '{1'b1, 3'd1, 8'h00, 8'h00};
    vt[18] = '{1'b0, 3'd1, 8'h00, 8'h00};

    repeat (3) @(negedge Xin);
    nRESET = 1;
    repeat (100) @(negedge Xin);
    chk("rst_ncs", int'(nCS), 15);
    chk("rst_sclk", int'(SCLK), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_irq", int'(irq), 0);
    chk("rst_mosi", int'(MOSI), 0);
    chk("rst_rdata", int'(rdata), 0);

    for (int i = 0; i < 19; i++) begin
      if (vt[i].is_wr) bus_wr(vt[i].a, vt[i].d);
      else begin
        bus_rd(vt[i].a, r8);
        chk($sformatf("vec%0d_addr%0d", i, vt[i].a), int'(r8), int'(vt[i].exp));
      end
    end

    // Single conversion, DIV=5, device 3 input 2
    bus_wr(3'd1, 8'd5);
    bus_wr(3'd0, 8'h1A);
    chk("single_ncs", int'(nCS), 7);
    wait_idle(2000, n);
    chk("single_busy_cycles", n, 34 * 5 + 1);
    chk("single_irq", int'(irq), 1);
    chk_frame("single_frame", 3, 2);
    bus_rd(3'd2, st);
    chk("single_status", int'(st & 8'h31), 'h10);
    bus_rd(3'd5, r8);
    chk("single_ridx", int'(r8), 26);
    read_pair(v);
    chk("single_data", v, exp_buf[26]);
    bus_rd(3'd2, st);
    chk("single_status_clr", int'(st & 8'h31), 0);
    chk("single_irq_clr", int'(irq), 0);

    // Random single conversions (DIV 0 behaves as 1)
    for (int k = 0; k < 6; k++) begin
      dv = $urandom_range(0, 3);
      deff = (dv == 0) ? 1 : dv;
      dev = $urandom_range(0, N_DEV - 1);
      ch = $urandom_range(0, N_IN - 1);
      bus_wr(3'd1, 8'(dv));
      bus_wr(3'd0, {2'b00, dev[2:0], ch[2:0]});
      wait_idle(2000, n);
      chk($sformatf("rnd%0d_busy_cycles", k), n, 34 * deff + 1);
      chk_frame($sformatf("rnd%0d_frame", k), dev, ch);
      bus_rd(3'd5, r8);
      chk($sformatf("rnd%0d_ridx", k), int'(r8), dev * N_IN + ch);
      read_pair(v);
      chk($sformatf("rnd%0d_data", k), v, exp_buf[dev * N_IN + ch]);
      bus_rd(3'd2, st);
    end

    // Full scan at DIV=1
    bus_wr(3'd1, 8'd1);
    bus_wr(3'd0, 8'h40);
    wait_idle(5000, n);
    chk("scan_busy_cycles", n, NCH * 35 + (NCH - 1) * 2);
    chk("scan_irq", int'(irq), 1);
    for (int i = 0; i < NCH; i++) chk_frame($sformatf("scan_frame%0d", i), i / N_IN, i % N_IN);
    bus_wr(3'd5, 8'd0);
    for (int i = 0; i < NCH; i++) begin
      read_pair(v);
      chk($sformatf("scan_data%0d", i), v, exp_buf[i]);
    end
    bus_rd(3'd5, r8);
    chk("scan_ridx_wrap", int'(r8), 0);
    bus_rd(3'd2, st);
    chk("scan_status", int'(st & 8'h31), 'h10);

    // Continuous scan: two pass-end events, then a stop request
    bus_wr(3'd0, 8'hC0);
    for (int e = 0; e < 2; e++) begin
      n = 0;
      while (!irq && n < 5000) begin n++; @(negedge Xin); end
      chk($sformatf("cont_done%0d_seen", e), int'(irq), 1);
      bus_rd(3'd2, st);
      chk($sformatf("cont_status%0d", e), int'(st & 8'h31), 'h11);
    end
    repeat (50) @(negedge Xin);
    bus_wr(3'd0, 8'hC0);
    wait_idle(5000, n);
    chk("cont_irq_end", int'(irq), 1);
    chk("cont_frames", fq.size() - fidx, 3 * NCH);
    fidx = fq.size();
    bus_rd(3'd2, st);
    chk("cont_status_end", int'(st & 8'h31), 'h10);
    bus_wr(3'd5, 8'd0);
    for (int i = 0; i < NCH; i++) begin
      read_pair(v);
      chk($sformatf("cont_data%0d", i), v, exp_buf[i]);
    end

    // Overrun: CMD during a single conversion, then an invalid device
    bus_wr(3'd0, 8'h00);
    repeat (5) @(negedge Xin);
    bus_wr(3'd0, 8'h08);
    wait_idle(2000, n);
    chk_frame("ovr_frame", 0, 0);
    chk("ovr_no_extra", fq.size() - fidx, 0);
    bus_rd(3'd2, st);
    chk("ovr_status_busywr", int'(st & 8'h31), 'h30);
    bus_wr(3'd0, 8'h28);
    busy_seen = 0;
    repeat (50) begin @(negedge Xin); if (busy || nCS != 4'hF) busy_seen = 1; end
    chk("ovr_baddev_idle", busy_seen, 0);
    chk("ovr_baddev_noframe", fq.size() - fidx, 0);
    bus_rd(3'd2, st);
    chk("ovr_status_baddev", int'(st & 8'h31), 'h20);

    // Reset in the middle of a frame, at SCLK fall 9
    bus_wr(3'd1, 8'd2);
    bus_wr(3'd0, 8'h0D);
    n = 0;
    while ((!act || falls < 9) && n < 2000) begin n++; @(negedge Xin); end
    chk("mid_reset_reached_fall9", int'(falls >= 9), 1);
    nRESET = 0;
    #1;
    chk("mid_reset_ncs", int'(nCS), 15);
    chk("mid_reset_sclk", int'(SCLK), 1);
    chk("mid_reset_busy", int'(busy), 0);
    chk("mid_reset_mosi", int'(MOSI), 0);
    @(negedge Xin);
    @(negedge Xin);
    nRESET = 1;
    chk("mid_reset_noframe", fq.size() - fidx, 0);
    bus_wr(3'd5, 8'd13);
    read_pair(v);
    chk("mid_reset_buf_zero", v, 0);
    bus_wr(3'd0, 8'h0D);
    wait_idle(2000, n);
    chk("post_reset_busy_cycles", n, 34 * DIV_RST + 1);
    chk_frame("post_reset_frame", 1, 5);
    bus_rd(3'd5, r8);
    chk("post_reset_ridx", int'(r8), 13);
    read_pair(v);
    chk("post_reset_data", v, exp_buf[13]);

    chk("ncs_onehot", int'(ncs_bad), 0);
    chk("mosi_zero_bits", int'(mosi_bad), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
